// File: rtl/telemetry.sv
// Periodic telemetry transmitter: snapshots batt/curr/torque on a fixed period and sends a framed 8N1 packet.
// Define TELEM_CHKSUM_EN to append a 9th byte holding the modular sum of bytes 2..7.
module telemetry #(
  parameter int FAST_SIM = 0,
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic [11:0] avg_curr,
  input  logic [11:0] avg_torque,
  output logic        TX,
  output logic        tx_busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

`ifdef TELEM_CHKSUM_EN
  localparam logic [3:0] LAST_BYTE = 4'd8;
`else
  localparam logic [3:0] LAST_BYTE = 4'd7;
`endif
  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  state_e      state_q, state_d;
  logic [19:0] pcnt_q;
  logic [11:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  byte_q, byte_d;
  logic [11:0] batt_q, curr_q, torq_q;
  logic        tx_q, tx_d, busy_q;
  logic        trig, cap;
  logic [7:0]  cur_byte;

  // Period keeps running through packets; overlapping triggers are simply ignored by the FSM.
  assign trig = (FAST_SIM != 0) ? (&pcnt_q[13:0]) : (&pcnt_q);

`ifdef TELEM_CHKSUM_EN
  logic [7:0] chksum;
  assign chksum = {4'h0, batt_q[11:8]} + batt_q[7:0] + {4'h0, curr_q[11:8]} + curr_q[7:0]
                + {4'h0, torq_q[11:8]} + torq_q[7:0];
`endif

  always_comb begin
    cur_byte = 8'h00;
    case (byte_q)
      4'd0: cur_byte = 8'hAA;
      4'd1: cur_byte = 8'h55;
      4'd2: cur_byte = {4'h0, batt_q[11:8]};
      4'd3: cur_byte = batt_q[7:0];
      4'd4: cur_byte = {4'h0, curr_q[11:8]};
      4'd5: cur_byte = curr_q[7:0];
      4'd6: cur_byte = {4'h0, torq_q[11:8]};
      4'd7: cur_byte = torq_q[7:0];
`ifdef TELEM_CHKSUM_EN
      4'd8: cur_byte = chksum;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    cap     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: if (trig) begin
        state_d = START;
        baud_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
        cap     = 1'b1;
      end
      START: if (baud_q == BAUD_LAST) begin
        state_d = DATA;
        baud_d  = '0;
        bit_d   = '0;
      end else baud_d = baud_q + 12'd1;
      DATA: if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_q == 3'd7) state_d = STOP;
        else bit_d = bit_q + 3'd1;
      end else baud_d = baud_q + 12'd1;
      STOP: if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (byte_q == LAST_BYTE) state_d = IDLE;
        else begin
          state_d = START;
          byte_d  = byte_q + 4'd1;
        end
      end else baud_d = baud_q + 12'd1;
      default: state_d = IDLE;
    endcase
    // TX is registered from the next state so the line moves on the same edge as the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      batt_q  <= '0;
      curr_q  <= '0;
      torq_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_q + 20'd1;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      if (cap) begin
        batt_q <= batt;
        curr_q <= avg_curr;
        torq_q <= avg_torque;
      end
    end
  end

  assign TX      = tx_q;
  assign tx_busy = busy_q;
endmodule

// File: tb/tb_telemetry.sv
// Scoreboard bench for telemetry: two instances (BAUD_DIV 16 and 300, FAST_SIM=1) with UART decode monitors.
module tb_telemetry;
`ifdef TELEM_CHKSUM_EN
  localparam int NB = 9, LEN0 = 1440, LEN1 = 27000;
`else
  localparam int NB = 8, LEN0 = 1280, LEN1 = 24000;
`endif
  localparam int D0 = 16, D1 = 300;

  // Expected packets, bytes b0..b8 (b8 used only with the checksum build).
  logic [71:0] P2 = 72'hAA_55_0A_BC_01_23_00_FF_E9; // batt=ABC curr=123 torq=0FF
  logic [71:0] PF = 72'hAA_55_0F_FF_0F_FF_0F_FF_2A; // all FFF
  logic [71:0] PR = 72'hAA_55_00_00_0F_FF_08_00_16; // batt=000 curr=FFF torq=800
  logic [71:0] PA = 72'hAA_55_05_A5_0A_5A_03_C3_D4; // batt=5A5 curr=A5A torq=3C3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n;
  logic [11:0] b0, c0, t0, b1, c1, t1;
  logic        tx0, busy0, tx1, busy1;
  logic [19:0] mc0, mc1;
  int          errors = 0, checks = 0;
  logic [7:0]  bq0[$], bq1[$];
  int          sq0[$], sq1[$];

  telemetry #(.FAST_SIM(1), .BAUD_DIV(D0)) u0 (
    .clk(clk), .rst_n(rst0_n), .batt(b0), .avg_curr(c0), .avg_torque(t0), .TX(tx0), .tx_busy(busy0));
  telemetry #(.FAST_SIM(1), .BAUD_DIV(D1)) u1 (
    .clk(clk), .rst_n(rst1_n), .batt(b1), .avg_curr(c1), .avg_torque(t1), .TX(tx1), .tx_busy(busy1));

  // Bench clock index since reset release.
  always @(posedge clk or negedge rst0_n) if (!rst0_n) mc0 <= '0; else mc0 <= mc0 + 20'd1;
  always @(posedge clk or negedge rst1_n) if (!rst1_n) mc1 <= '0; else mc1 <= mc1 + 20'd1;

  function automatic logic rstk(input int k); return (k == 0) ? rst0_n : rst1_n; endfunction
  function automatic logic txk(input int k); return (k == 0) ? tx0 : tx1; endfunction
  function automatic logic busyk(input int k); return (k == 0) ? busy0 : busy1; endfunction
  function automatic int mck(input int k); return (k == 0) ? int'(mc0) : int'(mc1); endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_pkt(input int k, input logic [71:0] p);
    for (int i = 0; i < NB; i++) begin
      if (k == 0) bq0.push_back(p[71-8*i -: 8]);
      else        bq1.push_back(p[71-8*i -: 8]);
    end
  endtask

  task automatic wait_n(input int k, input int n, output bit ab);
    ab = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rstk(k) == 1'b0) ab = 1'b1;
    end
  endtask

  // UART decoder: sample mid-bit, compare {stop,start,data} against the next queued byte.
  task automatic byte_mon(input int k, input int d);
    logic [7:0] v, e;
    logic s0, sp;
    bit ab, a2, empty;
    forever begin
      @(negedge clk);
      if (rstk(k) && txk(k) == 1'b0) begin
        wait_n(k, d/2, ab);
        s0 = txk(k);
        for (int i = 0; i < 8; i++) begin
          wait_n(k, d, a2); ab |= a2; v[i] = txk(k);
        end
        wait_n(k, d, a2); ab |= a2; sp = txk(k);
        if (!ab) begin
          empty = 1'b0; e = 8'h00;
          if (k == 0) begin if (bq0.size() == 0) empty = 1'b1; else e = bq0.pop_front(); end
          else        begin if (bq1.size() == 0) empty = 1'b1; else e = bq1.pop_front(); end
          if (empty) begin
            checks++; errors++;
            $display("FAIL byte%0d_unexpected: got %0h expected none", k, v);
          end else chk($sformatf("byte%0d", k), int'({sp, s0, v}), int'({1'b1, 1'b0, e}));
        end
      end
    end
  endtask

  task automatic busy_mon(input int k, input int len);
    bit inp = 1'b0;
    int st = 0;
    forever begin
      @(negedge clk);
      if (!rstk(k)) inp = 1'b0;
      else if (busyk(k) && !inp) begin
        inp = 1'b1; st = mck(k);
        if ((k == 0 ? sq0.size() : sq1.size()) == 0) begin
          checks++; errors++;
          $display("FAIL start%0d_unexpected: got %0d expected none", k, st);
        end else chk($sformatf("start%0d", k), st, (k == 0) ? sq0.pop_front() : sq1.pop_front());
      end else if (!busyk(k) && inp) begin
        inp = 1'b0;
        chk($sformatf("busy_len%0d", k), mck(k) - st, len);
      end
    end
  endtask

  initial byte_mon(0, D0);
  initial byte_mon(1, D1);
  initial busy_mon(0, LEN0);
  initial busy_mon(1, LEN1);

  task automatic wait_mc(input int k, input int n);
    while (mck(k) != n) @(negedge clk);
  endtask

  task automatic idle_window(input string nm);
    int bad = 0;
    while (int'(mc0) != 16384) begin
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
      @(negedge clk);
    end
    chk(nm, bad, 0);
    chk({nm, "_edge"}, int'({tx0, busy0}), 1);
  endtask

  task automatic seq0();
    idle_window("idle0");
    wait_mc(0, 32768 + 200);
    b0 = 12'hFFF; c0 = 12'hFFF; t0 = 12'hFFF;
    push_pkt(0, PF);
    wait_mc(0, 49152 + 563);
    rst0_n = 1'b0;
    #1;
    chk("rst_tx", int'(tx0), 1);
    chk("rst_busy", int'(busy0), 0);
    bq0.delete();
    repeat (20) @(negedge clk);
    b0 = 12'h000; c0 = 12'hFFF; t0 = 12'h800;
    push_pkt(0, PR);
    sq0.push_back(16384);
    rst0_n = 1'b1;
    idle_window("idle_after_rst");
    wait_mc(0, 16384 + LEN0 + 20);
  endtask

  task automatic seq1();
    wait_mc(1, 32770);
    chk("busy1_through_dropped_trig", int'(busy1), 1);
    wait_mc(1, 49151);
    chk("busy1_gap", int'(busy1), 0);
    wait_mc(1, 80000);
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    b0 = 12'hABC; c0 = 12'h123; t0 = 12'h0FF;
    b1 = 12'h5A5; c1 = 12'hA5A; t1 = 12'h3C3;
    push_pkt(0, P2); push_pkt(0, P2);
    sq0.push_back(16384); sq0.push_back(32768); sq0.push_back(49152);
    push_pkt(1, PA); push_pkt(1, PA);
    sq1.push_back(16384); sq1.push_back(49152);
    repeat (3) @(negedge clk);
    chk("reset_tx0", int'(tx0), 1);
    chk("reset_busy0", int'(busy0), 0);
    chk("reset_tx1", int'(tx1), 1);
    chk("reset_busy1", int'(busy1), 0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    fork
      seq0();
      seq1();
    join
    chk("drain_bytes0", bq0.size(), 0);
    chk("drain_starts0", sq0.size(), 0);
    chk("drain_bytes1", bq1.size(), 0);
    chk("drain_starts1", sq1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
